// File: rtl/adder_pkg.sv
// Shared defaults and the result record for the adder responder slice.
package adder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic                 carry;
    logic [DEF_WIDTH-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/adder_result_fifo.sv
// Small power-of-two result FIFO with registered occupancy; head is the oldest entry.
module adder_result_fifo import adder_pkg::*; #(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_responder.sv
// Adder responder: accepts operand pairs, buffers {carry,sum} results, and
// delivers them in order while counting completed transactions.
module adder_responder import adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic [CNT_W-1:0] txn_count
);

  localparam int RW = WIDTH + 1;

  logic [RW-1:0] add_full;
  logic [RW-1:0] head;
  logic [RW-1:0] last_result;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign add_full  = {1'b0, in1} + {1'b0, in0};
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  adder_result_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (RW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (add_full),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // Remember the last delivered result so the outputs hold it while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_result <= '0;
      txn_count   <= '0;
    end else if (pop) begin
      last_result <= head;
      txn_count   <= txn_count + CNT_W'(1);
    end
  end

  assign {carry_out, sum_out} = out_valid ? head : last_result;

endmodule

// File: tb/tb_adder_responder.sv
// Directed bench for adder_responder: table of single adds plus backpressure,
// streaming, mid-operation reset and a narrow-counter wrap sequence.
module tb_adder_responder;
  import adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in1;
  logic [7:0]  in0;

  logic        in_ready;
  logic        out_valid;
  logic [7:0]  sum_out;
  logic        carry_out;
  logic [15:0] txn_count;

  logic        in_ready_c4;
  logic        out_valid_c4;
  logic [7:0]  sum_out_c4;
  logic        carry_out_c4;
  logic [3:0]  txn_count_c4;

  int checks   = 0;
  int failures = 0;
  int exp_txn  = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    add_result_t exp;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  adder_responder u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in0       (in0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .txn_count (txn_count)
  );

  adder_responder #(.CNT_W(4)) u_dut_c4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_c4),
    .in1       (in1),
    .in0       (in0),
    .out_valid (out_valid_c4),
    .out_ready (out_ready),
    .sum_out   (sum_out_c4),
    .carry_out (carry_out_c4),
    .txn_count (txn_count_c4)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input logic ev, input logic er,
                            input logic [7:0] es, input logic ec);
    logic [31:0] t16;
    logic [31:0] t4;
    t16 = 32'(exp_txn) & 32'h0000_FFFF;
    t4  = 32'(exp_txn) & 32'h0000_000F;
    checkOutput({name, ".out_valid"}, 32'(out_valid), 32'(ev));
    checkOutput({name, ".in_ready"},  32'(in_ready),  32'(er));
    checkOutput({name, ".sum_out"},   32'(sum_out),   32'(es));
    checkOutput({name, ".carry_out"}, 32'(carry_out), 32'(ec));
    checkOutput({name, ".txn_count"}, 32'(txn_count), t16);
    checkOutput({name, ".c4_out_valid"}, 32'(out_valid_c4), 32'(ev));
    checkOutput({name, ".c4_in_ready"},  32'(in_ready_c4),  32'(er));
    checkOutput({name, ".c4_sum"},       32'({carry_out_c4, sum_out_c4}), 32'({ec, es}));
    checkOutput({name, ".c4_txn"},       32'(txn_count_c4), t4);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic ordy);
    in_valid  = v;
    in1       = a;
    in0       = b;
    out_ready = ordy;
  endtask

  initial begin
    vecs[0] = '{8'h0F, 8'h01, '{1'b0, 8'h10}};
    vecs[1] = '{8'hFF, 8'h01, '{1'b1, 8'h00}};
    vecs[2] = '{8'hFF, 8'hFF, '{1'b1, 8'hFE}};
    vecs[3] = '{8'h00, 8'h00, '{1'b0, 8'h00}};
    vecs[4] = '{8'h80, 8'h80, '{1'b1, 8'h00}};
    vecs[5] = '{8'h7F, 8'h01, '{1'b0, 8'h80}};
    vecs[6] = '{8'hA5, 8'h5A, '{1'b0, 8'hFF}};

    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    checkState("reset", 1'b0, 1'b1, 8'h00, 1'b0);
    rst = 1'b0;

    // Single adds: accept with no backpressure, then pop and confirm hold.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, 1'b0);
      @(negedge clk);
      checkState($sformatf("vec%0d_acc", i), 1'b1, 1'b1, vecs[i].exp.sum, vecs[i].exp.carry);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
      exp_txn++;
      @(negedge clk);
      checkState($sformatf("vec%0d_pop", i), 1'b0, 1'b1, vecs[i].exp.sum, vecs[i].exp.carry);
    end

    // Backpressure: fill, hold a third pair while full, then drain in order.
    applyStimulus(1'b1, 8'd1, 8'd1, 1'b0);
    @(negedge clk);
    checkState("bp_push1", 1'b1, 1'b1, 8'd2, 1'b0);
    applyStimulus(1'b1, 8'd2, 8'd2, 1'b0);
    @(negedge clk);
    checkState("bp_full", 1'b1, 1'b0, 8'd2, 1'b0);
    applyStimulus(1'b1, 8'd3, 8'd3, 1'b0);
    @(negedge clk);
    checkState("bp_held", 1'b1, 1'b0, 8'd2, 1'b0);
    applyStimulus(1'b1, 8'd3, 8'd3, 1'b1);
    exp_txn++;
    @(negedge clk);
    checkState("bp_pop1", 1'b1, 1'b1, 8'd4, 1'b0);
    exp_txn++;
    @(negedge clk);
    checkState("bp_pop2", 1'b1, 1'b1, 8'd6, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    exp_txn++;
    @(negedge clk);
    checkState("bp_drain", 1'b0, 1'b1, 8'd6, 1'b0);

    // Streaming: one push and one pop per cycle keeps a single entry queued.
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 8'(i), 8'(i), 1'b1);
      if (i > 1) exp_txn++;
      @(negedge clk);
      checkState($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(2 * i), 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    exp_txn++;
    @(negedge clk);
    checkState("stream_end", 1'b0, 1'b1, 8'd20, 1'b0);
    checkOutput("stream_total", 32'(txn_count), 32'd20);

    // Reset with two buffered results: outputs clear at once, nothing stale after.
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'h40, 8'h40, 1'b0);
    @(negedge clk);
    checkState("mid_full", 1'b1, 1'b0, 8'h30, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    #1 rst = 1'b1;
    exp_txn = 0;
    #1 checkState("mid_rst", 1'b0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    checkState("post_rst1", 1'b0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    checkState("post_rst2", 1'b0, 1'b1, 8'h00, 1'b0);

    // Seventeen deliveries wrap the 4-bit counter instance to 1.
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b1, 8'(k), 8'd1, 1'b1);
      if (k > 0) exp_txn++;
      @(negedge clk);
      checkState($sformatf("wrap%0d", k), 1'b1, 1'b1, 8'(k + 1), 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    exp_txn++;
    @(negedge clk);
    checkState("wrap_end", 1'b0, 1'b1, 8'h11, 1'b0);
    checkOutput("wrap_c4", 32'(txn_count_c4), 32'd1);
    checkOutput("wrap_c16", 32'(txn_count), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_responder.md
Name: adder_responder

Overview:
- DUT-side responder for the adder bench interface (in1, in0, sum_out, carry_out).
- Accepts operand pairs under a valid/ready handshake and computes the (WIDTH+1)-bit sum.
- Buffers results in a small FIFO so the bench can apply backpressure on the result side.
- Returns each result with carry split out, in order, with a running transaction counter for scoreboard cross-checks.

Parameters:
- WIDTH, 8, operand and sum width in bits
- DEPTH, 2, result buffer entries; power of two, >= 2
- CNT_W, 16, transaction counter width

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  responder can accept a pair this cycle
- in1  input  WIDTH  operand 1
- in0  input  WIDTH  operand 0
- out_valid  output  1  result at buffer head is valid
- out_ready  input  1  consumer takes the head result this cycle
- sum_out  output  WIDTH  low WIDTH bits of in1+in0 for the head entry
- carry_out  output  1  bit WIDTH of in1+in0 for the head entry
- txn_count  output  CNT_W  number of results delivered (out_valid && out_ready) since reset

Behaviour:
- Reset (asynchronous assert, synchronous deassert at the top level):
  - buffer emptied; occupancy = 0
  - in_ready = 1, out_valid = 0, sum_out = 0, carry_out = 0, txn_count = 0
- Accept:
  - A pair is accepted on a posedge where in_valid && in_ready.
  - {carry, sum} = {1'b0, in1} + {1'b0, in0}, computed in WIDTH+1 bits.
  - The result is written to the buffer tail on that same edge.
- Latency: a result accepted at edge N appears at the head with out_valid = 1 after edge N, provided the buffer was empty; otherwise it queues behind earlier results.
- Ordering: strict FIFO; results leave in acceptance order.
- in_ready:
  - in_ready = (occupancy < DEPTH), registered-state based.
  - Depends only on occupancy, never combinationally on out_ready.
  - When full, in_ready = 0 even if out_ready = 1 in the same cycle.
- Deliver:
  - The head is popped on a posedge where out_valid && out_ready.
  - sum_out/carry_out hold stable while out_valid && !out_ready.
  - sum_out/carry_out hold the last delivered value when out_valid = 0, and 0 after reset.
- Simultaneous push and pop (not full, not empty): occupancy unchanged; both take effect.
- Pop when empty: ignored (out_valid = 0, so no pop occurs).
- Push when full: impossible because in_ready = 0; in_valid is ignored.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- txn_count: increments by 1 per delivered result and wraps from 2^CNT_W-1 to 0 without saturation.
- Reset mid-operation: all buffered results are discarded, no partial delivery occurs, and all outputs return to their reset values immediately.
- Inputs are sampled on posedge. The bench drives them on negedge, so they have a half-cycle setup; no internal sampling on negedge.

Decomposition:
- Package adder_pkg:
  - default WIDTH constant
  - typedef struct packed {logic carry; logic [WIDTH-1:0] sum;} add_result_t, sized by the package default; the responder uses WIDTH-parameterised logic internally
  - CNT_W default
- Sub-module adder_result_fifo:
  - parameters DEPTH and data width
  - push/pop/full/empty/head ports
- adder_responder owns: handshake, add, txn_count.

Test Plan:
- Reset then single add: in1=8'h0F, in0=8'h01, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, sum_out=8'h10, carry_out=0; txn_count=1 after pop.
- Carry/overflow: in1=8'hFF, in0=8'h01 -> sum_out=8'h00, carry_out=1. Then 8'hFF+8'hFF -> sum_out=8'hFE, carry_out=1.
- Backpressure fill: out_ready=0, push 3 pairs (1+1, 2+2, 3+3):
  - first two accepted, in_ready=0 after 2nd, third held
  - raise out_ready -> results 2, 4, 6 delivered in order
  - third accepted only after first pop
- Streaming: in_valid=1 and out_ready=1 for 10 cycles, in1=i, in0=i -> one result per cycle, sum_out=2i, occupancy constant at 1, txn_count=10.
- Reset mid-operation: buffer holding 2 results with out_ready=0, assert rst -> out_valid=0, in_ready=1, txn_count=0 immediately; no stale results after release.
- Counter wrap (CNT_W=4): deliver 17 results -> txn_count reads 1.
